// File: rtl/uart_rx_frame.sv
// UART receive framer: oversamples the synchronized serial line, recovers
// start / data (LSB first) / optional parity / stop, and hands a checked byte
// to the system controller with one-cycle valid and error strobes.
module uart_rx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [PRESCALE_WIDTH-1:0] p_lat;
    logic                      par_en_lat;
    logic                      par_typ_lat;
    logic                      bad;
    logic [DATA_WIDTH-1:0]     shreg;
    logic [2:0]                smp;

    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] smp_a;
    logic [PRESCALE_WIDTH-1:0] smp_b;
    logic [PRESCALE_WIDTH-1:0] smp_c;
    logic [PRESCALE_WIDTH-1:0] edge_last;
    logic                      at_last;
    logic                      bit_val;
    logic                      par_exp;

    // Unsupported oversampling ratios fall back to 8 so a bad setting can
    // never produce a zero-length bit period.
    function automatic logic [PRESCALE_WIDTH-1:0] decode_prescale(
        input logic [PRESCALE_WIDTH-1:0] p
    );
        if (p == PRESCALE_WIDTH'(16))
            return PRESCALE_WIDTH'(16);
        else if (p == PRESCALE_WIDTH'(32))
            return PRESCALE_WIDTH'(32);
        else
            return PRESCALE_WIDTH'(8);
    endfunction

    // Three samples straddle the bit centre; the decision is made later at
    // the end of the bit period, when the vote is long settled.
    assign half      = p_lat >> 1;
    assign smp_a     = half - PRESCALE_WIDTH'(1);
    assign smp_b     = half;
    assign smp_c     = half + PRESCALE_WIDTH'(1);
    assign edge_last = p_lat - PRESCALE_WIDTH'(1);
    assign at_last   = (edge_cnt == edge_last);
    assign bit_val   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign par_exp   = (^shreg) ^ par_typ_lat;

    // Capture the three centre samples of the current bit for the majority vote.
    always_ff @(posedge CLK) begin
        if (state != IDLE) begin
            if (edge_cnt == smp_a) smp[0] <= RX_IN;
            if (edge_cnt == smp_b) smp[1] <= RX_IN;
            if (edge_cnt == smp_c) smp[2] <= RX_IN;
        end
    end

    // Shift each voted data bit in from the top so bit 0 ends up in the LSB.
    always_ff @(posedge CLK) begin
        if (state == DATA && at_last)
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
    end

    // Frame sequencer: bit timing, framing checks and registered strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            p_lat       <= PRESCALE_WIDTH'(8);
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            bad         <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE)
                edge_cnt <= at_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    bad      <= 1'b0;
                    if (!RX_IN) begin
                        // Configuration is frozen for the whole frame here.
                        state       <= START;
                        p_lat       <= decode_prescale(Prescale);
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                    end
                end
                START: begin
                    if (at_last)
                        state <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (at_last) begin
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (at_last) begin
                        if (bit_val != par_exp) begin
                            par_err <= 1'b1;
                            bad     <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (at_last) begin
                        if (!bit_val) begin
                            stp_err <= 1'b1;
                        end else if (!bad) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        bad   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: drives whole frames bit by bit at the
// selected prescale and checks the output strobes, data and latency.
module tb_uart_rx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int tests_run = 0;
    int tests_failed = 0;

    uart_rx_frame #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .par_err(par_err),
        .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    // Rising-edge counter used to time data_valid against start detection.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         dv_cyc = 0;
    logic [7:0] dv_log [0:15];
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_log[dv_cnt[3:0]] <= P_DATA;
            dv_cnt              <= dv_cnt + 1;
            dv_cyc              <= cyc;
        end
        if (par_err) pe_cnt <= pe_cnt + 1;
        if (stp_err) se_cnt <= se_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edge index on which the current frame's start bit is first seen.
    int det = 0;

    // Drive one frame; optionally invert a single oversample (bit gb, cycle gc).
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input int gb, input int gc);
        logic [10:0] fr;
        int          n;
        int          p;
        p  = (Prescale == 6'd16) ? 16 : (Prescale == 6'd32) ? 32 : 8;
        fr = '1;
        fr[0]   = 1'b0;
        fr[8:1] = d;
        if (PAR_EN) begin
            fr[9]  = par_bit;
            fr[10] = stop_bit;
            n      = 11;
        end else begin
            fr[9] = stop_bit;
            n     = 10;
        end
        det = cyc + 1;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = (b == gb && c == gc) ? ~fr[b] : fr[b];
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(negedge CLK);
        #1;
    endtask

    int dv0, pe0, se0, idx;

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_pe", 32'(par_err), 32'h0);
        check("rst_se", 32'(stp_err), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // P=8, no parity, 0xA5
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
        settle();
        check("a5_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("a5_pdata", 32'(P_DATA), 32'hA5);
        check("a5_pe", 32'(pe_cnt - pe0), 32'd0);
        check("a5_se", 32'(se_cnt - se0), 32'd0);
        check("a5_latency", 32'(dv_cyc - det), 32'd80);

        // P=16, even parity, good then bad parity
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0);
        settle();
        check("3c_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("3c_pdata", 32'(P_DATA), 32'h3C);
        check("3c_pe", 32'(pe_cnt - pe0), 32'd0);
        check("3c_latency", 32'(dv_cyc - det), 32'd176);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, -1, 0);
        settle();
        check("badpar_pe", 32'(pe_cnt - pe0), 32'd1);
        check("badpar_dv", 32'(dv_cnt - dv0), 32'd0);
        check("badpar_se", 32'(se_cnt - se0), 32'd0);
        check("badpar_pdata", 32'(P_DATA), 32'h3C);

        // P=32, odd parity correct, stop bit low
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h01, 1'b0, 1'b0, -1, 0);
        settle();
        check("stp_se", 32'(se_cnt - se0), 32'd1);
        check("stp_dv", 32'(dv_cnt - dv0), 32'd0);
        check("stp_pe", 32'(pe_cnt - pe0), 32'd0);
        check("stp_pdata", 32'(P_DATA), 32'h3C);

        // P=8, 3-cycle start glitch rejected
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        #1;
        check("glitch_dv", 32'(dv_cnt - dv0), 32'd0);
        check("glitch_pe", 32'(pe_cnt - pe0), 32'd0);
        check("glitch_se", 32'(se_cnt - se0), 32'd0);

        // 0x55 with one inverted centre sample in data bit 0
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 1, 5);
        settle();
        check("vote_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("vote_pdata", 32'(P_DATA), 32'h55);

        // Back-to-back frames at P=16 with no idle gap
        Prescale = 6'd16;
        dv0 = dv_cnt; se0 = se_cnt;
        send_frame(8'h12, 1'b0, 1'b1, -1, 0);
        send_frame(8'h34, 1'b0, 1'b1, -1, 0);
        settle();
        check("b2b_dv_cnt", 32'(dv_cnt - dv0), 32'd2);
        idx = dv0;
        check("b2b_first", 32'(dv_log[idx[3:0]]), 32'h12);
        idx = dv0 + 1;
        check("b2b_second", 32'(dv_log[idx[3:0]]), 32'h34);
        check("b2b_se", 32'(se_cnt - se0), 32'd0);

        // Reset during data bit 4 of a P=8 frame
        Prescale = 6'd8;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (8 * 4 + 3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midrst_pdata", 32'(P_DATA), 32'h0);
        check("midrst_dv", 32'(data_valid), 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (90) @(negedge CLK);
        #1;
        check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
        check("midrst_no_err", 32'(pe_cnt - pe0 + se_cnt - se0), 32'd0);
        check("midrst_pdata_held", 32'(P_DATA), 32'h0);

        // Fresh frame after reset, with a config change mid-frame
        dv0 = dv_cnt;
        fork
            send_frame(8'hFF, 1'b0, 1'b1, -1, 0);
            begin
                repeat (20) @(negedge CLK);
                Prescale = 6'd32;
                PAR_EN   = 1'b1;
            end
        join
        settle();
        check("ff_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("ff_pdata", 32'(P_DATA), 32'hFF);
        check("ff_latency", 32'(dv_cyc - det), 32'd80);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
